mod503_chunk_reduce_ctrl: RTL and testbench

- Sequential controller that reduces a 300-bit operand modulo 503.
- Streams the operand, 6 bits per cycle, through the shared chunk-residue LUT bank (one 6-in/9-out LUT per chunk position, selected by chunk index).
- Accumulates the returned residues modulo 503.
- Sits between the operand producer and the result consumer of the mod-503 calculator. It owns sequencing of the LUT bank and valid/ready handshakes on both sides.

---
 rtl/mod503_chunk_reduce_ctrl.sv | 109 ++++++++++
 tb/tb_mod503_chunk_reduce_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mod503_chunk_reduce_ctrl.sv
// Sequential mod-503 reducer: streams a wide operand through a shared chunk-residue
// LUT bank one CHUNK_W slice per cycle and accumulates the returned residues mod MOD.
module mod503_chunk_reduce_ctrl #(
  parameter int OP_W    = 300,
  parameter int CHUNK_W = 6,
  parameter int MOD     = 503,
  parameter int RES_W   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_data,
  output logic [5:0]         lut_idx,
  output logic [CHUNK_W-1:0] lut_x,
  input  logic [RES_W-1:0]   lut_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_res,
  output logic               busy,
  output logic               lut_err
);
  localparam int NCHUNK = OP_W / CHUNK_W;
  localparam logic [RES_W-1:0] MOD_R    = RES_W'(MOD);
  localparam logic [5:0]       LAST_IDX = 6'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   shift_q, shift_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [5:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [RES_W:0]    sum, red;

  // One conditional subtract is exact while both addends are below MOD.
  assign sum = {1'b0, acc_q} + {1'b0, lut_z};
  assign red = (sum >= {1'b0, MOD_R}) ? sum - {1'b0, MOD_R} : sum;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lut_idx   = '0;
    lut_x     = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        lut_idx = idx_q;
        lut_x   = shift_q[CHUNK_W-1:0];
        acc_d   = red[RES_W-1:0];
        shift_d = shift_q >> CHUNK_W;
        idx_d   = idx_q + 6'd1;
        if (lut_z >= MOD_R) err_d = 1'b1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle capture.
    if (flush) begin
      state_d = S_IDLE;
      shift_d = shift_q;
      acc_d   = '0;
      idx_d   = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign out_res = acc_q;
  assign lut_err = err_q;

endmodule

// File: tb/tb_mod503_chunk_reduce_ctrl.sv
// Directed + random bench for the mod-503 chunk reducer with a behavioural LUT bank.
module tb_mod503_chunk_reduce_ctrl;
  localparam int OP_W    = 300;
  localparam int CHUNK_W = 6;
  localparam int MOD     = 503;
  localparam int RES_W   = 9;
  localparam int NCHUNK  = OP_W / CHUNK_W;

  logic               clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy, lut_err;
  logic [OP_W-1:0]    in_data;
  logic [5:0]         lut_idx;
  logic [CHUNK_W-1:0] lut_x;
  logic [RES_W-1:0]   lut_z, out_res;
  bit                 force_err;
  int                 nchk, nerr;

  mod503_chunk_reduce_ctrl #(.OP_W(OP_W), .CHUNK_W(CHUNK_W), .MOD(MOD), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lut_idx(lut_idx), .lut_x(lut_x), .lut_z(lut_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy), .lut_err(lut_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lutf(input int idx, input int x);
    int p = 1;
    for (int i = 0; i < idx; i++) p = (p * 64) % MOD;
    return (x * p) % MOD;
  endfunction

  // Bit-serial Horner reference, independent of the chunked datapath.
  function automatic int modref(input logic [OP_W-1:0] d);
    int r = 0;
    for (int i = OP_W - 1; i >= 0; i--) r = (r * 2 + int'(d[i])) % MOD;
    return r;
  endfunction

  always_comb begin
    lut_z = 9'(lutf(int'(lut_idx), int'(lut_x)));
    if (force_err && lut_idx == 6'd3) lut_z = 9'd510;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_res"}, out_res, 0);
    chk({tag, "_idx"}, lut_idx, 0);
    chk({tag, "_x"}, lut_x, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, lut_err, 0);
  endtask

  task automatic start_op(input logic [OP_W-1:0] d);
    @(negedge clk);
    chk("acc_rdy", in_ready, 1);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic no_valid_for(input string tag, input int cyc);
    int seen = 0, nrdy = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (out_valid) seen++;
      if (!in_ready) nrdy++;
    end
    chk({tag, "_novld"}, seen, 0);
    chk({tag, "_rdy"}, nrdy, 0);
  endtask

  task automatic do_op(input logic [OP_W-1:0] d, input int stall, input bit fin_flush, input bit chk_lat);
    int n, exp, held;
    logic [OP_W-1:0] sh;
    exp = modref(d);
    start_op(d);
    n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (out_valid) break;
      chk("rdy_run", in_ready, 0);
      chk("busy_run", busy, 1);
      chk("idx", lut_idx, n - 1);
      sh = d >> (CHUNK_W * (n - 1));
      chk("lut_x", lut_x, int'(sh[CHUNK_W-1:0]));
      chk("err_run", lut_err, (force_err && n >= 5) ? 1 : 0);
    end
    if (!out_valid) begin
      chk("done_timeout", 0, 1);
      return;
    end
    if (chk_lat) chk("latency", n, NCHUNK + 1);
    chk("busy_done", busy, 1);
    chk("rdy_done", in_ready, 0);
    held = out_res;
    if (!force_err) chk("res", out_res, exp);
    repeat (stall) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_vld", out_valid, 1);
      chk("stall_res", out_res, held);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1'b1; flush = fin_flush;
    @(posedge clk); #1 out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("vld_fall", out_valid, 0);
    chk("rdy_idle", in_ready, 1);
    chk("busy_idle", busy, 0);
    chk("idx_idle", lut_idx, 0);
    chk("x_idle", lut_x, 0);
    if (!fin_flush) chk("res_hold", out_res, held);
    if (force_err) chk("err_sticky", lut_err, 1);
  endtask

  initial begin
    logic [OP_W-1:0] d;
    nchk = 0; nerr = 0; force_err = 1'b0;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    do_op(OP_W'(4095), 0, 1'b0, 1'b1);
    do_op(OP_W'(503), 0, 1'b0, 1'b1);
    do_op(OP_W'(1000), 2, 1'b0, 1'b1);
    do_op(OP_W'(64), 0, 1'b0, 1'b1);
    do_op(OP_W'(502), 1, 1'b0, 1'b1);
    do_op('1, 3, 1'b0, 1'b1);

    // Flush mid-RUN: no result for the aborted operand.
    start_op(OP_W'(4095));
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_run_rdy", in_ready, 1);
    chk("flush_run_busy", busy, 0);
    no_valid_for("flush_run", 60);

    // Flush beats a same-cycle capture.
    @(negedge clk);
    in_data = OP_W'(1000); in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);
    no_valid_for("flush_idle", 60);
    do_op(OP_W'(4095), 0, 1'b0, 1'b1);

    // flush with out_ready in DONE consumes the result exactly once.
    do_op(OP_W'(1000), 2, 1'b1, 1'b1);
    no_valid_for("flush_done", 5);

    // Bad LUT residue: sticky error, still 50 RUN cycles; cleared on next accept.
    force_err = 1'b1;
    do_op(OP_W'(4095), 1, 1'b0, 1'b1);
    do_op(OP_W'(1000), 0, 1'b0, 1'b1);
    force_err = 1'b0;
    do_op(OP_W'(64), 0, 1'b0, 1'b1);

    // Async reset at RUN cycle 20 discards the job.
    force_err = 1'b1;
    start_op(OP_W'(4095));
    repeat (20) @(negedge clk);
    chk("pre_rst_err", lut_err, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    chk_reset_vals("mid_rst_hold");
    rst_n = 1'b1; force_err = 1'b0;
    no_valid_for("post_rst", 60);
    do_op(OP_W'(502), 0, 1'b0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < OP_W; i++) d[i] = 1'($urandom_range(0, 1));
      do_op(d, $urandom_range(0, 3), 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
